// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage of a 5-stage RV32I pipeline.
//
// Keeps the fetch PC and issues word fetches over a request/grant interface.
// Responses come back in request order, with variable latency.
// Up to two returned instructions wait in an in-order fetch queue.
// The queue head is presented to ID.
// An EX-stage redirect squashes queued work and in-flight work.
//
// Ports
//   clk          in   pipeline clock, rising edge
//   rst          in   asynchronous active-low reset
//   EN           in   ID accepts the presented instruction (0 = stall)
//   redirect     in   EX-stage control-flow change
//   redirect_pc  in   new fetch address (bits [1:0] ignored)
//   imem_req     out  fetch request
//   imem_addr    out  word-aligned fetch address
//   imem_gnt     in   request accepted this cycle
//   imem_rvalid  in   response valid (in request order)
//   imem_rdata   in   fetched instruction
//   IR_ID        out  instruction presented to ID (0 when empty)
//   PCurrent_ID  out  PC of IR_ID (0 when empty)
//   valid_ID     out  IR_ID/PCurrent_ID hold a real instruction
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR_ID,
    output logic [31:0] PCurrent_ID,
    output logic        valid_ID
);

    // Architectural state
    logic [31:0] r_fpc;
    logic [1:0]  r_inflight;
    logic [1:0]  r_disc;
    logic [1:0]  r_count;
    // In-flight PC FIFO; entry 0 is the oldest outstanding request.
    logic [31:0] r_ipc0;
    logic [31:0] r_ipc1;
    // Fetch queue; entry 0 is the head, and empty slots are kept at zero.
    // This lets the outputs drive straight from entry 0.
    logic [31:0] r_qpc0;
    logic [31:0] r_qpc1;
    logic [31:0] r_qins0;
    logic [31:0] r_qins1;

    // Control terms
    logic        w_valid;
    logic        w_pop;
    logic [2:0]  w_occ;
    logic        w_req;
    logic        w_issue;
    logic        w_rsp;
    logic        w_keep;
    logic        w_drop;
    logic [1:0]  w_islot;
    logic [1:0]  w_qslot;

    // Next-state values
    logic [31:0] w_fpc_n;
    logic [1:0]  w_inflight_n;
    logic [1:0]  w_disc_n;
    logic [1:0]  w_count_n;
    logic [31:0] w_ipc0_n;
    logic [31:0] w_ipc1_n;
    logic [31:0] w_qpc0_n;
    logic [31:0] w_qpc1_n;
    logic [31:0] w_qins0_n;
    logic [31:0] w_qins1_n;

    // Handshake decode: pop, issue and response qualification
    always_comb begin
        w_valid = (r_count != 2'd0);
        w_pop   = EN & w_valid & ~redirect;
        // Occupancy after this cycle's pop.
        // Issue only if a slot remains for the new request's data.
        w_occ   = {1'b0, r_inflight} + {1'b0, r_count} - {2'b00, w_pop};
        w_req   = ~redirect & (w_occ < 3'd2);
        w_issue = w_req & imem_gnt;
        // A response with nothing outstanding is a protocol violation and is ignored.
        w_rsp   = imem_rvalid & (r_inflight != 2'd0);
        w_keep  = w_rsp & (r_disc == 2'd0) & ~redirect;
        w_drop  = w_rsp & (r_disc != 2'd0);
        w_islot = r_inflight - {1'b0, w_rsp};
        w_qslot = r_count - {1'b0, w_pop};
    end

    // Next-state for fetch PC and counters
    always_comb begin
        w_fpc_n      = r_fpc;
        w_inflight_n = r_inflight + {1'b0, w_issue} - {1'b0, w_rsp};
        w_disc_n     = r_disc;
        w_count_n    = r_count;
        if (redirect) begin
            w_fpc_n   = {redirect_pc[31:2], 2'b00};
            // Every request still outstanding after this cycle belongs to the squashed path.
            w_disc_n  = r_inflight - {1'b0, w_rsp};
            w_count_n = 2'd0;
        end else begin
            w_fpc_n   = w_issue ? (r_fpc + 32'd4) : r_fpc;
            w_disc_n  = w_drop ? (r_disc - 2'd1) : r_disc;
            w_count_n = r_count - {1'b0, w_pop} + {1'b0, w_keep};
        end
    end

    // Next-state for the in-flight PC FIFO and the fetch queue (shift-to-head)
    always_comb begin
        w_ipc0_n = (w_issue && (w_islot == 2'd0)) ? r_fpc : (w_rsp ? r_ipc1 : r_ipc0);
        w_ipc1_n = (w_issue && (w_islot == 2'd1)) ? r_fpc : r_ipc1;
        if (redirect) begin
            w_qpc0_n  = 32'h0000_0000;
            w_qins0_n = 32'h0000_0000;
            w_qpc1_n  = 32'h0000_0000;
            w_qins1_n = 32'h0000_0000;
        end else begin
            w_qpc0_n  = (w_keep && (w_qslot == 2'd0)) ? r_ipc0     : (w_pop ? r_qpc1  : r_qpc0);
            w_qins0_n = (w_keep && (w_qslot == 2'd0)) ? imem_rdata : (w_pop ? r_qins1 : r_qins0);
            w_qpc1_n  = (w_keep && (w_qslot == 2'd1)) ? r_ipc0     : (w_pop ? 32'h0000_0000 : r_qpc1);
            w_qins1_n = (w_keep && (w_qslot == 2'd1)) ? imem_rdata : (w_pop ? 32'h0000_0000 : r_qins1);
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fpc      <= RESET_PC;
            r_inflight <= 2'd0;
            r_disc     <= 2'd0;
            r_count    <= 2'd0;
            r_ipc0     <= 32'h0000_0000;
            r_ipc1     <= 32'h0000_0000;
            r_qpc0     <= 32'h0000_0000;
            r_qpc1     <= 32'h0000_0000;
            r_qins0    <= 32'h0000_0000;
            r_qins1    <= 32'h0000_0000;
        end else begin
            r_fpc      <= w_fpc_n;
            r_inflight <= w_inflight_n;
            r_disc     <= w_disc_n;
            r_count    <= w_count_n;
            r_ipc0     <= w_ipc0_n;
            r_ipc1     <= w_ipc1_n;
            r_qpc0     <= w_qpc0_n;
            r_qpc1     <= w_qpc1_n;
            r_qins0    <= w_qins0_n;
            r_qins1    <= w_qins1_n;
        end
    end

    // Outputs: the request is combinational; everything else comes from registers
    always_comb begin
        imem_req    = w_req;
        imem_addr   = r_fpc;
        valid_ID    = w_valid;
        IR_ID       = r_qins0;
        PCurrent_ID = r_qpc0;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        EN;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] IR_ID;
    logic [31:0] PCurrent_ID;
    logic        valid_ID;

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .EN(EN), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IR_ID(IR_ID), .PCurrent_ID(PCurrent_ID), .valid_ID(valid_ID)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: outstanding fetches (with a squashed flag), the fetch queue, and the fetch PC
    typedef struct { logic [31:0] pc; bit stale; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } fq_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;
    fl_t  m_fl[$];
    fq_t  m_fq[$];
    mem_t mem_q[$];
    logic [31:0] m_fpc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; EN = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        #1;
        check_eq("rst_valid", {31'h0, valid_ID}, 32'h0);
        check_eq("rst_ir", IR_ID, 32'h0);
        check_eq("rst_pc", PCurrent_ID, 32'h0);
        check_eq("rst_addr", imem_addr, RESET_PC);
        check_eq("rst_req", {31'h0, imem_req}, 32'h1);
        m_fl.delete(); m_fq.delete(); mem_q.delete();
        m_fpc = RESET_PC;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then advance the model
    task automatic cycle(input int lat_min, input int lat_max, input int en_pct,
                         input int redir_pct, input int gnt_pct);
        bit    e_valid, pop, e_req, rsp;
        fl_t   e;
        int    occ;
        @(negedge clk);
        cyc++;
        EN          = ($urandom_range(0, 99) < en_pct);
        redirect    = ($urandom_range(0, 99) < redir_pct);
        redirect_pc = (redir_pct >= 100) ? 32'h0000_0100 : ($urandom & 32'h0000_03FF);
        imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(mem_q[0].addr);
        end else if (mem_q.size() == 0 && $urandom_range(0, 15) == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        e_valid = (m_fq.size() != 0);
        pop     = EN && e_valid && !redirect;
        occ     = m_fl.size() + m_fq.size() - (pop ? 1 : 0);
        e_req   = !redirect && (occ < 2);
        check_eq("imem_req", {31'h0, imem_req}, {31'h0, e_req});
        check_eq("imem_addr", imem_addr, m_fpc);
        check_eq("valid_ID", {31'h0, valid_ID}, {31'h0, e_valid});
        check_eq("PCurrent_ID", PCurrent_ID, e_valid ? m_fq[0].pc : 32'h0);
        check_eq("IR_ID", IR_ID, e_valid ? m_fq[0].ins : 32'h0);
        if (valid_ID) n_valid++;
        // Advance the model to the state after the coming rising edge
        rsp = imem_rvalid && (m_fl.size() > 0);
        if (rsp) void'(mem_q.pop_front());
        if (redirect) begin
            if (rsp) void'(m_fl.pop_front());
            foreach (m_fl[i]) m_fl[i].stale = 1'b1;
            m_fq.delete();
            m_fpc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (pop) void'(m_fq.pop_front());
            if (rsp) begin
                e = m_fl.pop_front();
                if (!e.stale) m_fq.push_back('{pc: e.pc, ins: imem_rdata});
            end
            if (e_req && imem_gnt) begin
                m_fl.push_back('{pc: m_fpc, stale: 1'b0});
                mem_q.push_back('{addr: m_fpc, due: cyc + $urandom_range(lat_min, lat_max)});
                m_fpc = m_fpc + 32'd4;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        do_reset();

        // 1-cycle memory with EN high: one instruction per cycle from cycle 2
        n_valid = 0;
        for (int i = 0; i < 20; i++) cycle(1, 1, 100, 0, 100);
        check_eq("throughput", n_valid, 32'd18);

        // Stall for 5 cycles, then resume
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 100);
        for (int i = 0; i < 10; i++) cycle(1, 1, 100, 0, 100);

        // 3-cycle memory
        for (int i = 0; i < 20; i++) cycle(3, 3, 100, 0, 100);
        // Redirect to 0x100 with fetches in flight
        cycle(3, 3, 100, 100, 100);
        for (int i = 0; i < 15; i++) cycle(3, 3, 100, 0, 100);

        // Redirect that lands on a response with EN high
        for (int i = 0; i < 4; i++) cycle(1, 1, 100, 0, 100);
        cycle(1, 1, 100, 100, 100);
        for (int i = 0; i < 10; i++) cycle(1, 1, 100, 0, 100);

        // Random mix
        for (int i = 0; i < 2000; i++) cycle(1, 4, 70, 5, 70);

        // Fill the queue under stall, then reset mid-stream
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 100);
        do_reset();
        for (int i = 0; i < 1000; i++) cycle(1, 3, 60, 4, 80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
